// File: rtl/pll_lock_ctrl.sv
// PLL lock controller.
// Watches the synchronized PFD up/dn pulses over fixed activity windows and
// sequences the loop filter through IDLE -> FLUSH -> ACQUIRE -> LOCKED.
// ACQUIRE uses the coarse loop-filter step and LOCKED uses the fine step.
// A loop filter that sits at either rail for too long is restarted through
// FLUSH, and that event is recorded in a sticky flag.
// Every output is a register that mirrors the state being entered, so each
// output is always a decode of the current state.
module pll_lock_ctrl #(
  parameter int bit_count     = 24,
  parameter int window        = 256,
  parameter int lock_thresh   = 8,
  parameter int unlock_thresh = 32,
  parameter int lock_windows  = 4,
  parameter int flush_cycles  = 4,
  parameter int rail_limit    = 1024,
  parameter logic [bit_count-1:0] max_speed = {bit_count{1'b1}},
  parameter logic [bit_count-1:0] min_speed = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_up,
  input  logic                 i_dn,
  input  logic [bit_count-1:0] i_speed_var,
  output logic                 o_lf_rst,
  output logic [1:0]           o_gain_sel,
  output logic                 o_freeze,
  output logic                 o_locked,
  output logic [1:0]           o_state,
  output logic                 o_rail_err,
  output logic [7:0]           o_lose_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FLUSH   = 2'd1;
  localparam logic [1:0] ACQUIRE = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  localparam logic [1:0] GAIN_COARSE = 2'b10;
  localparam logic [1:0] GAIN_FINE   = 2'b00;

  localparam int WIN_W  = $clog2(window);
  localparam int ACT_W  = $clog2(unlock_thresh + 1);
  localparam int GOOD_W = $clog2(lock_windows + 1);
  localparam int FL_W   = $clog2(flush_cycles + 1);
  localparam int RAIL_W = $clog2(rail_limit + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(window - 1);
  localparam logic [ACT_W-1:0]  ACT_MAX   = ACT_W'(unlock_thresh);
  localparam logic [ACT_W-1:0]  ACT_QUIET = ACT_W'(lock_thresh);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(lock_windows - 1);
  localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(flush_cycles - 1);
  localparam logic [RAIL_W-1:0] RAIL_LAST = RAIL_W'(rail_limit - 1);

  logic [1:0]        r_state;
  logic              r_up_s1, r_up_s2, r_dn_s1, r_dn_s2;
  logic [WIN_W-1:0]  r_win;
  logic [ACT_W-1:0]  r_act;
  logic [GOOD_W-1:0] r_good;
  logic [FL_W-1:0]   r_fl;
  logic [RAIL_W-1:0] r_rail;
  logic              r_rail_err;
  logic [7:0]        r_lose_cnt;
  logic              r_lf_rst, r_freeze, r_locked;
  logic [1:0]        r_gain_sel;

  logic [1:0]        w_next;
  logic              w_entry;
  logic              w_active;
  logic              w_win_state;
  logic              w_win_end;
  logic [ACT_W-1:0]  w_act_tot;
  logic              w_quiet;
  logic              w_noisy;
  logic              w_rail_hit;
  logic              w_rail_to;
  logic              w_good_reach;

  // Window bookkeeping: activity includes the current cycle, so the
  // window-end decision sees every active cycle of the window.
  always_comb begin
    w_active     = r_up_s2 ^ r_dn_s2;
    w_win_state  = (r_state == ACQUIRE) || (r_state == LOCKED);
    w_win_end    = w_win_state && (r_win == WIN_LAST);
    w_act_tot    = (w_active && (r_act != ACT_MAX)) ? r_act + ACT_W'(1) : r_act;
    w_quiet      = (w_act_tot <= ACT_QUIET);
    w_noisy      = (w_act_tot >= ACT_MAX);
    w_rail_hit   = (i_speed_var == max_speed) || (i_speed_var == min_speed);
    w_rail_to    = (r_state == ACQUIRE) && w_rail_hit && (r_rail == RAIL_LAST);
    w_good_reach = (r_state == ACQUIRE) && w_win_end && w_quiet && (r_good == GOOD_LAST);
  end

  // Next-state selection; dropping enable overrides everything, and a rail
  // timeout beats a lock decision landing on the same cycle.
  always_comb begin
    w_next = r_state;
    if (!i_enable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = FLUSH;
        FLUSH:   if (r_fl == FL_LAST) w_next = ACQUIRE;
        ACQUIRE: begin
          if (w_rail_to)         w_next = FLUSH;
          else if (w_good_reach) w_next = LOCKED;
        end
        LOCKED:  if (w_win_end && w_noisy) w_next = ACQUIRE;
        default: w_next = IDLE;
      endcase
    end
    w_entry = (w_next != r_state);
  end

  // State register and the two-flop synchronizers for the PFD pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_up_s1 <= 1'b0;
      r_up_s2 <= 1'b0;
      r_dn_s1 <= 1'b0;
      r_dn_s2 <= 1'b0;
    end else begin
      r_state <= w_next;
      r_up_s1 <= i_up;
      r_up_s2 <= r_up_s1;
      r_dn_s1 <= i_dn;
      r_dn_s2 <= r_dn_s1;
    end
  end

  // Cycle/activity/good-window/flush/rail counters; every one restarts when
  // the state changes so each state begins from a clean slate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_win  <= '0;
      r_act  <= '0;
      r_good <= '0;
      r_fl   <= '0;
      r_rail <= '0;
    end else begin
      if (w_entry || !w_win_state || w_win_end) r_win <= '0;
      else                                      r_win <= r_win + WIN_W'(1);

      if (w_entry || !w_win_state || w_win_end) r_act <= '0;
      else                                      r_act <= w_act_tot;

      if (w_entry || (r_state != ACQUIRE)) r_good <= '0;
      else if (w_win_end)                  r_good <= w_quiet ? r_good + GOOD_W'(1) : '0;

      if (w_entry || (r_state != FLUSH)) r_fl <= '0;
      else                               r_fl <= r_fl + FL_W'(1);

      if (w_entry || (r_state != ACQUIRE) || !w_rail_hit) r_rail <= '0;
      else                                                r_rail <= r_rail + RAIL_W'(1);
    end
  end

  // Sticky status: rail restarts and saturating loss-of-lock count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rail_err <= 1'b0;
      r_lose_cnt <= '0;
    end else begin
      if ((r_state == ACQUIRE) && (w_next == FLUSH)) r_rail_err <= 1'b1;
      if ((r_state == LOCKED) && (w_next == ACQUIRE) && (r_lose_cnt != 8'hFF))
        r_lose_cnt <= r_lose_cnt + 8'd1;
    end
  end

  // Output registers track the state being entered so they always match r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lf_rst   <= 1'b0;
      r_freeze   <= 1'b1;
      r_locked   <= 1'b0;
      r_gain_sel <= GAIN_FINE;
    end else begin
      r_lf_rst   <= (w_next == FLUSH);
      r_freeze   <= (w_next == IDLE);
      r_locked   <= (w_next == LOCKED);
      r_gain_sel <= (w_next == ACQUIRE) ? GAIN_COARSE : GAIN_FINE;
    end
  end

  assign o_state    = r_state;
  assign o_lf_rst   = r_lf_rst;
  assign o_freeze   = r_freeze;
  assign o_locked   = r_locked;
  assign o_gain_sel = r_gain_sel;
  assign o_rail_err = r_rail_err;
  assign o_lose_cnt = r_lose_cnt;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with a small configuration:
// window=16, lock_thresh=2, unlock_thresh=8, lock_windows=2,
// flush_cycles=4, rail_limit=8.
module tb_pll_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        up;
  logic        dn;
  logic [23:0] speed_var;
  logic        lf_rst;
  logic [1:0]  gain_sel;
  logic        freeze;
  logic        locked;
  logic [1:0]  state;
  logic        rail_err;
  logic [7:0]  lose_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [23:0] MID_SPEED = 24'd1000;
  localparam logic [23:0] TOP_SPEED = 24'd16777215;

  pll_lock_ctrl #(
    .bit_count(24), .window(16), .lock_thresh(2), .unlock_thresh(8),
    .lock_windows(2), .flush_cycles(4), .rail_limit(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_up(up), .i_dn(dn),
    .i_speed_var(speed_var), .o_lf_rst(lf_rst), .o_gain_sel(gain_sel),
    .o_freeze(freeze), .o_locked(locked), .o_state(state),
    .o_rail_err(rail_err), .o_lose_cnt(lose_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a state; an expired budget shows up as a failed check.
  task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (state === s) break;
      tick();
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},    32'(state),    32'd0);
    check({tag, "_freeze"},   32'(freeze),   32'd1);
    check({tag, "_lf_rst"},   32'(lf_rst),   32'd0);
    check({tag, "_gain"},     32'(gain_sel), 32'd0);
    check({tag, "_locked"},   32'(locked),   32'd0);
    check({tag, "_rail_err"}, 32'(rail_err), 32'd0);
    check({tag, "_lose_cnt"}, 32'(lose_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; up = 1'b0; dn = 1'b0; speed_var = MID_SPEED;
    repeat (3) tick();
    check_reset_vals("reset");

    // Bring-up: FLUSH for 4 cycles, ACQUIRE for 32, then LOCKED.
    rst = 1'b0; enable = 1'b1;
    tick();
    check("flush_enter_state", 32'(state), 32'd1);
    check("flush_enter_lf_rst", 32'(lf_rst), 32'd1);
    check("flush_enter_freeze", 32'(freeze), 32'd0);
    repeat (3) tick();
    check("flush_last_state", 32'(state), 32'd1);
    tick();
    check("acq_enter_state", 32'(state), 32'd2);
    check("acq_enter_lf_rst", 32'(lf_rst), 32'd0);
    check("acq_gain", 32'(gain_sel), 32'd2);
    repeat (31) tick();
    check("acq_before_lock", 32'(state), 32'd2);
    check("acq_before_lock_locked", 32'(locked), 32'd0);
    tick();
    check("lock_state", 32'(state), 32'd3);
    check("lock_locked", 32'(locked), 32'd1);
    check("lock_gain", 32'(gain_sel), 32'd0);

    // up high for 10 cycles inside one LOCKED window -> lose lock at window end.
    up = 1'b1;
    repeat (10) tick();
    up = 1'b0;
    repeat (5) tick();
    check("noisy_still_locked", 32'(state), 32'd3);
    tick();
    check("unlock_state", 32'(state), 32'd2);
    check("unlock_locked", 32'(locked), 32'd0);
    check("unlock_lose_cnt", 32'(lose_cnt), 32'd1);
    check("unlock_gain", 32'(gain_sel), 32'd2);

    // up=dn=1 counts as inactive, so lock arrives after exactly 32 cycles.
    up = 1'b1; dn = 1'b1;
    repeat (31) tick();
    check("both_high_acq", 32'(state), 32'd2);
    tick();
    check("both_high_lock", 32'(state), 32'd3);
    up = 1'b0; dn = 1'b0;

    // Drop enable in LOCKED and mid-FLUSH.
    enable = 1'b0;
    tick();
    check("dis_locked_state", 32'(state), 32'd0);
    check("dis_locked_freeze", 32'(freeze), 32'd1);
    check("dis_locked_locked", 32'(locked), 32'd0);
    enable = 1'b1;
    tick();
    check("reen_flush", 32'(state), 32'd1);
    tick();
    enable = 1'b0;
    tick();
    check("dis_flush_state", 32'(state), 32'd0);
    check("dis_flush_lf_rst", 32'(lf_rst), 32'd0);
    check("dis_flush_freeze", 32'(freeze), 32'd1);
    enable = 1'b1;
    tick();
    check("reen2_flush", 32'(state), 32'd1);
    repeat (4) tick();
    check("reen2_acq", 32'(state), 32'd2);

    // Rail held 7 cycles then released: no restart.
    speed_var = TOP_SPEED;
    repeat (7) tick();
    speed_var = MID_SPEED;
    tick();
    check("rail7_state", 32'(state), 32'd2);
    check("rail7_err", 32'(rail_err), 32'd0);

    // Rail held 8 cycles, ending on a window end: rail restart wins.
    speed_var = TOP_SPEED;
    repeat (7) tick();
    check("rail8_pre", 32'(state), 32'd2);
    tick();
    check("rail8_state", 32'(state), 32'd1);
    check("rail8_err", 32'(rail_err), 32'd1);
    check("rail8_lf_rst", 32'(lf_rst), 32'd1);
    speed_var = MID_SPEED;
    repeat (4) tick();
    check("rail_recover_acq", 32'(state), 32'd2);
    check("rail_err_sticky", 32'(rail_err), 32'd1);

    // 256 more loss-of-lock events; count saturates at 255.
    for (int i = 0; i < 256; i++) begin
      wait_state("loop_lock", 2'd3, 100);
      up = 1'b1;
      tick();
      wait_state("loop_unlock", 2'd2, 100);
      up = 1'b0;
      if (i == 252) check("lose_cnt_254", 32'(lose_cnt), 32'd254);
    end
    check("lose_cnt_sat", 32'(lose_cnt), 32'd255);

    // Reset mid-ACQUIRE with enable still high.
    repeat (5) tick();
    check("pre_rst_acq", 32'(state), 32'd2);
    rst = 1'b1;
    tick();
    check_reset_vals("mid_rst");
    rst = 1'b0;
    tick();
    check("post_rst_flush", 32'(state), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameters: bit_count=24, speed word width; window=256, cycles per activity window (>=4); lock_thresh=8, max active cycles in a window counted as quiet; unlock_thresh=32, active cycles in a window that declare loss of lock; lock_windows=4, consecutive quiet windows required to lock; flush_cycles=4, length of lf_rst pulse; rail_limit=1024, consecutive rail cycles before restart; max_speed=16777215; min_speed=0.
REQ-002 clk  in  1  sole clock, all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 enable  in  1  acquisition request; low forces IDLE.
REQ-005 up  in  1  PFD up, asynchronous to clk.
REQ-006 dn  in  1  PFD down, asynchronous to clk.
REQ-007 speed_var  in  bit_count  current loop filter output.
REQ-008 lf_rst  out  1  loop filter reset, high during FLUSH.
REQ-009 gain_sel  out  2  loop filter step select: 2'b10 coarse, 2'b00 fine.
REQ-010 freeze  out  1  hold loop filter value, high in IDLE.
REQ-011 locked  out  1  high only in LOCKED.
REQ-012 state  out  2  IDLE=0, FLUSH=1, ACQUIRE=2, LOCKED=3.
REQ-013 rail_err  out  1  sticky; set on rail restart.
REQ-014 lose_cnt  out  8  saturating count of LOCKED->ACQUIRE exits.

Function
REQ-015 up/dn SHALL each pass through a two-flop synchronizer; active = up_s2 XOR dn_s2 (both high or both low = inactive).
REQ-016 Window counter SHALL run 0..window-1 in ACQUIRE and LOCKED, clear to 0 on entry to either state; window end = cycle counter equals window-1.
REQ-017 Activity counter SHALL count active cycles within the window including the end cycle, saturate at unlock_thresh, clear at window end and on state entry.
REQ-018 IDLE: freeze=1, gain_sel=2'b00; enable=1 -> FLUSH next cycle.
REQ-019 FLUSH: lf_rst=1 for exactly flush_cycles cycles, then ACQUIRE; good-window counter cleared.
REQ-020 ACQUIRE: gain_sel=2'b10; at window end, activity<=lock_thresh increments good-window count, else clears it; count reaching lock_windows -> LOCKED on the following cycle.
REQ-021 Rail: in ACQUIRE, speed_var==max_speed or ==min_speed for rail_limit consecutive cycles -> FLUSH next cycle and rail_err<=1; the rail counter clears on any non-rail cycle and on state entry.
REQ-022 LOCKED: locked=1, gain_sel=2'b00; at window end, activity>=unlock_thresh -> ACQUIRE, good-window count cleared, lose_cnt+1 saturating at 255.
REQ-023 enable=0 in any state SHALL force IDLE next cycle with priority over all other transitions; counters clear.
REQ-024 Window end coincident with rail timeout in ACQUIRE: rail timeout wins (FLUSH).
REQ-025 All outputs SHALL be registered and decoded from the current state; no combinational input-to-output path.
REQ-026 rail_err and lose_cnt clear only on rst.

Reset
REQ-027 While rst=1 at a clock edge: state=IDLE, freeze=1, lf_rst=0, gain_sel=2'b00, locked=0, rail_err=0, lose_cnt=0, synchronizers and all counters 0.
REQ-028 rst asserted mid-operation SHALL take effect at the next edge, regardless of enable.

Verification (window=16, lock_thresh=2, unlock_thresh=8, lock_windows=2, flush_cycles=4, rail_limit=8)
REQ-029 rst, then enable=1, up=dn=0 -> FLUSH 4 cycles lf_rst=1, ACQUIRE gain_sel=2'b10, locked=1 after 2 windows (32 cycles).
REQ-030 LOCKED, then up toggled high for 10 cycles of one window -> ACQUIRE at that window end, locked=0, lose_cnt=1.
REQ-031 ACQUIRE with speed_var=16777215 held 8 cycles -> FLUSH, rail_err=1; speed_var drops on cycle 7 -> no restart.
REQ-032 up=dn=1 continuously in ACQUIRE -> counted inactive, lock achieved on schedule.
REQ-033 enable dropped mid-FLUSH and mid-LOCKED -> IDLE next cycle, freeze=1; re-enable restarts at FLUSH.
REQ-034 Force 256 loss-of-lock events -> lose_cnt holds 255; rst mid-ACQUIRE -> all REQ-027 values next cycle.
